sequence_generator: RTL and testbench
=====================================

Name: sequence_generator

Overview:
Serial pattern transmitter that drives the value/update strobe interface consumed by the team's serial sequence detectors (for example, the 1011 Mealy detector). On a start request it latches an up-to-PATTERN_WIDTH-bit pattern and shifts it out MSB-first. Each bit is presented on value and then qualified by one low-to-high update edge. It is used as a stimulus source on the board and as the transmit end in detector loopback tests.

Parameters:
PATTERN_WIDTH, 8, maximum number of bits per transfer
PERIOD_WIDTH, 8, width of the half_period input (cycles per strobe phase)

Ports:
clk  input  1  system clock, all logic on posedge
reset  input  1  reset, synchronous, active-high
start  input  1  transfer request, sampled only in IDLE
pattern  input  PATTERN_WIDTH  bits to send, sent MSB-first from bit length-1
length  input  $clog2(PATTERN_WIDTH+1)  number of bits to send, 0..PATTERN_WIDTH
half_period  input  PERIOD_WIDTH  cycles per SETUP phase and per STROBE phase
value  output  1  serial data bit, stable for the whole SETUP and STROBE phases of a bit
update  output  1  bit strobe; rising edge marks value valid
busy  output  1  high from the first SETUP cycle to the last STROBE cycle
done  output  1  one-cycle pulse after the final strobe phase

Behaviour:
- Reset (sync): state=IDLE; value=0, update=0, busy=0, done=0; counters cleared. Reset mid-transfer aborts immediately: update is low from the next edge, no done pulse is issued, and the partial sequence is discarded.
- All outputs are registered. No combinational path exists from inputs to outputs.
- FSM states: IDLE, SETUP, STROBE, DONE.
- IDLE:
  - start=1 with eff_len>0: latch pattern, eff_len and eff_hp. Go to SETUP next cycle with value=pattern[eff_len-1], update=0, busy=1.
  - start=1 with eff_len=0: go to DONE with no strobe.
- eff_len = min(length, PATTERN_WIDTH). eff_hp = (half_period==0) ? 1 : half_period.
- SETUP: update=0, value held. Lasts eff_hp cycles, then go to STROBE.
- STROBE: update=1, value unchanged. Lasts eff_hp cycles. Then:
  - if bits remain, go to SETUP with value set to the next lower bit;
  - otherwise go to DONE.
- DONE: done=1, busy=0, update=0, value=0 for exactly one cycle, then IDLE.
- value is 0 in IDLE and DONE.
- Timing: with start sampled at edge 0, the first SETUP begins at cycle 1. Each bit takes 2*eff_hp cycles. done is high at cycle 1+2*eff_hp*eff_len.
- Every bit, including consecutive equal bits, produces its own update low-high edge. A receiver therefore sees exactly eff_len rising edges.
- start while not IDLE: ignored, with no queuing. start held high across DONE begins a new transfer in the cycle after DONE (back-to-back). The minimum update-low gap between transfers is 2 cycles.
- pattern, length and half_period changes during busy have no effect; all three are latched at start.
- Phase counter width: PERIOD_WIDTH. Bit counter width: $clog2(PATTERN_WIDTH+1). Counters must not wrap; they compare against the latched terminal value.

Decomposition:
- Shared package seq_pkg holds:
  - the state encoding localparams (IDLE/SETUP/STROBE/DONE, 2 bits);
  - LOW/HIGH constants.
- The detector and generator import the same package.
- One natural sub-module: phase_timer. It loads eff_hp and pulses expire when the count reaches its terminal value. It is reused for both phases.

Test Plan:
- pattern=8'b0000_1011, length=4, half_period=2, start pulse at cycle 0 -> busy 1..16; update high at cycles 3-4, 7-8, 11-12, 15-16; value 1,0,1,1 per bit; done=1 only at cycle 17.
- Loopback into the 1011 sequence detector with the same stimulus -> sequence_detected goes high after the 4th update rise and stays low before it. Repeat with pattern 1111 (length 4) -> exactly 4 update rising edges counted.
- length=0, start -> no update edge; done at cycle 1; busy never high.
- half_period=0, length=2, pattern=2'b10 -> behaves as half_period=1: update high at cycles 2 and 4; done at cycle 5.
- start re-pulsed and pattern changed at cycle 5 of a length-4 transfer -> ignored; original bits are sent. start held high -> second transfer's first SETUP begins at cycle after done.
- reset asserted at cycle 6 mid-transfer -> from cycle 7: update=0, value=0, busy=0, no done pulse. A fresh start afterwards transmits a full, correct pattern.

Source files
------------

// File: rtl/seq_pkg.sv
// Shared definitions for the serial sequence generator and the detectors it drives.
// Holds the transfer state encoding and the strobe logic levels.
package seq_pkg;

  typedef enum logic [1:0] {
    StIdle   = 2'd0,
    StSetup  = 2'd1,
    StStrobe = 2'd2,
    StDone   = 2'd3
  } seq_state_e;

  localparam logic Low  = 1'b0;
  localparam logic High = 1'b1;

endpackage

// File: rtl/sequence_generator_phase_timer.sv
// Phase duration timer: load starts a phase at count 1, expire_o is high while the
// count equals the latched terminal value. The count saturates there instead of wrapping.
module sequence_generator_phase_timer #(
  parameter int unsigned Width = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load_i,
  input  logic [Width-1:0] terminal_i,
  output logic             expire_o
);

  logic [Width-1:0] cnt_q, cnt_d;

  assign expire_o = (cnt_q == terminal_i);

  always_comb begin
    cnt_d = cnt_q;
    if (load_i) begin
      cnt_d = Width'(1);
    end else if (!expire_o) begin
      cnt_d = cnt_q + Width'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/sequence_generator.sv
// Serial pattern transmitter: shifts a latched pattern out MSB-first, one update
// low-to-high strobe per bit, with a one-cycle done pulse after the final strobe.
module sequence_generator
  import seq_pkg::*;
#(
  parameter int unsigned PATTERN_WIDTH = 8,
  parameter int unsigned PERIOD_WIDTH  = 8,
  localparam int unsigned LenW         = $clog2(PATTERN_WIDTH + 1)
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     start_i,
  input  logic [PATTERN_WIDTH-1:0] pattern_i,
  input  logic [LenW-1:0]          length_i,
  input  logic [PERIOD_WIDTH-1:0]  half_period_i,
  output logic                     value_o,
  output logic                     update_o,
  output logic                     busy_o,
  output logic                     done_o
);

  seq_state_e                 state_q, state_d;
  logic [PATTERN_WIDTH-1:0]   shift_q, shift_d;
  logic [LenW-1:0]            len_q, len_d;
  logic [LenW-1:0]            bit_q, bit_d;
  logic [PERIOD_WIDTH-1:0]    hp_q, hp_d;
  logic                       value_q, value_d;
  logic                       update_q, update_d;
  logic                       busy_q, busy_d;
  logic                       done_q, done_d;
  logic [LenW-1:0]            eff_len;
  logic [PERIOD_WIDTH-1:0]    eff_hp;
  logic                       load;
  logic                       expire;

  assign eff_len = (length_i > LenW'(PATTERN_WIDTH)) ? LenW'(PATTERN_WIDTH) : length_i;
  assign eff_hp  = (half_period_i == '0) ? PERIOD_WIDTH'(1) : half_period_i;

  sequence_generator_phase_timer #(
    .Width(PERIOD_WIDTH)
  ) u_phase_timer (
    .clk       (clk),
    .reset     (reset),
    .load_i    (load),
    .terminal_i(hp_q),
    .expire_o  (expire)
  );

  always_comb begin
    state_d = state_q;
    shift_d = shift_q;
    len_d   = len_q;
    bit_d   = bit_q;
    hp_d    = hp_q;
    load    = Low;
    unique case (state_q)
      // DONE accepts start too, so a held start runs transfers back-to-back.
      StIdle, StDone: begin
        if (start_i) begin
          if (eff_len != '0) begin
            state_d = StSetup;
            // Left-align so the first bit to send always sits in the MSB.
            shift_d = pattern_i << (LenW'(PATTERN_WIDTH) - eff_len);
            len_d   = eff_len;
            hp_d    = eff_hp;
            bit_d   = LenW'(1);
            load    = High;
          end else begin
            state_d = StDone;
          end
        end else begin
          state_d = StIdle;
        end
      end
      StSetup: begin
        if (expire) begin
          state_d = StStrobe;
          load    = High;
        end
      end
      StStrobe: begin
        if (expire) begin
          if (bit_q == len_q) begin
            state_d = StDone;
          end else begin
            state_d = StSetup;
            shift_d = shift_q << 1;
            bit_d   = bit_q + LenW'(1);
            load    = High;
          end
        end
      end
      default: state_d = StIdle;
    endcase

    busy_d   = (state_d == StSetup) || (state_d == StStrobe);
    value_d  = busy_d ? shift_d[PATTERN_WIDTH-1] : Low;
    update_d = (state_d == StStrobe);
    done_d   = (state_d == StDone);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= StIdle;
      shift_q  <= '0;
      len_q    <= '0;
      bit_q    <= '0;
      hp_q     <= '0;
      value_q  <= Low;
      update_q <= Low;
      busy_q   <= Low;
      done_q   <= Low;
    end else begin
      state_q  <= state_d;
      shift_q  <= shift_d;
      len_q    <= len_d;
      bit_q    <= bit_d;
      hp_q     <= hp_d;
      value_q  <= value_d;
      update_q <= update_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
    end
  end

  assign value_o  = value_q;
  assign update_o = update_q;
  assign busy_o   = busy_q;
  assign done_o   = done_q;

endmodule

// File: tb/tb_sequence_generator.sv
// Directed bench for sequence_generator: per-cycle checks of value/update/busy/done
// plus a receiver that samples value on each update rise and looks for 1011.
module tb_sequence_generator;

  logic       clk;
  logic       reset;
  logic       start;
  logic [7:0] pattern;
  logic [3:0] length;
  logic [7:0] half_period;
  logic       value_o;
  logic       update_o;
  logic       busy_o;
  logic       done_o;

  int         n_checks;
  int         n_fail;
  int         rises;
  int         det_rise;
  int         stray;
  logic [7:0] rx;
  logic       upd_prev;

  sequence_generator #(
    .PATTERN_WIDTH(8),
    .PERIOD_WIDTH (8)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .start_i      (start),
    .pattern_i    (pattern),
    .length_i     (length),
    .half_period_i(half_period),
    .value_o      (value_o),
    .update_o     (update_o),
    .busy_o       (busy_o),
    .done_o       (done_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Advance to 1 time unit after the next posedge; track update rises like a receiver.
  task automatic tick();
    @(posedge clk);
    #1;
    if (update_o === 1'b1 && upd_prev !== 1'b1) begin
      rises++;
      rx = {rx[6:0], value_o};
      if (det_rise == 0 && rx[3:0] == 4'b1011) det_rise = rises;
    end
    upd_prev = update_o;
  endtask

  task automatic clear_rx();
    rises    = 0;
    rx       = '0;
    det_rise = 0;
  endtask

  // Expected outputs at cycle c after the start edge, for effective len and half period.
  function automatic void model(input int c, input logic [7:0] pat, input int len,
                                input int hp, output logic v, output logic u,
                                output logic b, output logic d);
    int t;
    t = 2 * hp * len;
    v = 1'b0;
    u = 1'b0;
    b = 1'b0;
    d = 1'b0;
    if (c >= 1 && c <= t) begin
      b = 1'b1;
      u = ((c - 1) % (2 * hp)) >= hp;
      v = pat[len - 1 - (c - 1) / (2 * hp)];
    end else if (c == t + 1) begin
      d = 1'b1;
    end
  endfunction

  task automatic check_cycle(input string tag, input int c, input logic [7:0] pat,
                             input int len, input int hp);
    logic v, u, b, d;
    model(c, pat, len, hp, v, u, b, d);
    chk($sformatf("%s c%0d value", tag, c), 32'(value_o), 32'(v));
    chk($sformatf("%s c%0d update", tag, c), 32'(update_o), 32'(u));
    chk($sformatf("%s c%0d busy", tag, c), 32'(busy_o), 32'(b));
    chk($sformatf("%s c%0d done", tag, c), 32'(done_o), 32'(d));
  endtask

  task automatic run(input string tag, input logic [7:0] pat, input int len, input int hp,
                     input int ncyc);
    for (int c = 1; c <= ncyc; c++) begin
      check_cycle(tag, c, pat, len, hp);
      tick();
    end
  endtask

  task automatic launch(input logic [7:0] pat, input logic [3:0] len, input logic [7:0] hp);
    pattern     = pat;
    length      = len;
    half_period = hp;
    start       = 1'b1;
    clear_rx();
    tick();
    start = 1'b0;
  endtask

  initial begin
    n_checks    = 0;
    n_fail      = 0;
    stray       = 0;
    upd_prev    = 1'b0;
    reset       = 1'b1;
    start       = 1'b0;
    pattern     = '0;
    length      = '0;
    half_period = '0;
    clear_rx();
    tick();
    tick();
    chk("reset value", 32'(value_o), 32'd0);
    chk("reset update", 32'(update_o), 32'd0);
    chk("reset busy", 32'(busy_o), 32'd0);
    chk("reset done", 32'(done_o), 32'd0);
    reset = 1'b0;
    tick();

    // 1011, hp=2: update high 3-4,7-8,11-12,15-16; done at 17.
    launch(8'b0000_1011, 4'd4, 8'd2);
    run("t1011", 8'b0000_1011, 4, 2, 20);
    chk("t1011 rises", 32'(rises), 32'd4);
    chk("t1011 rx", 32'(rx[3:0]), 32'b1011);
    chk("t1011 detect at rise", 32'(det_rise), 32'd4);

    // 1111: four distinct strobes for four equal bits, no 1011 match.
    launch(8'b0000_1111, 4'd4, 8'd1);
    run("t1111", 8'b0000_1111, 4, 1, 12);
    chk("t1111 rises", 32'(rises), 32'd4);
    chk("t1111 rx", 32'(rx[3:0]), 32'b1111);
    chk("t1111 no detect", 32'(det_rise), 32'd0);

    // length 0: done at cycle 1, nothing else.
    launch(8'hFF, 4'd0, 8'd3);
    run("tlen0", 8'hFF, 0, 3, 4);
    chk("tlen0 rises", 32'(rises), 32'd0);

    // length 12 clamps to 8 bits.
    launch(8'h96, 4'd12, 8'd1);
    run("tclamp", 8'h96, 8, 1, 19);
    chk("tclamp rises", 32'(rises), 32'd8);
    chk("tclamp rx", 32'(rx), 32'h96);

    // half_period 0 acts as 1: update at 2 and 4, done at 5.
    launch(8'b0000_0010, 4'd2, 8'd0);
    run("thp0", 8'b0000_0010, 2, 1, 7);
    chk("thp0 rises", 32'(rises), 32'd2);
    chk("thp0 rx", 32'(rx[1:0]), 32'b10);

    // start re-pulsed with new inputs at cycle 5: ignored.
    launch(8'b0000_0110, 4'd4, 8'd1);
    for (int c = 1; c <= 11; c++) begin
      check_cycle("trepulse", c, 8'b0000_0110, 4, 1);
      if (c == 5) begin
        start       = 1'b1;
        pattern     = 8'hFF;
        length      = 4'd8;
        half_period = 8'd3;
      end else begin
        start = 1'b0;
      end
      tick();
    end
    chk("trepulse rises", 32'(rises), 32'd4);
    chk("trepulse rx", 32'(rx[3:0]), 32'b0110);

    // start held: second transfer's SETUP at cycle 10, right after done at 9.
    pattern     = 8'b0000_0110;
    length      = 4'd4;
    half_period = 8'd1;
    start       = 1'b1;
    clear_rx();
    tick();
    for (int c = 1; c <= 9; c++) begin
      check_cycle("tb2b first", c, 8'b0000_0110, 4, 1);
      tick();
    end
    start = 1'b0;
    for (int c = 10; c <= 19; c++) begin
      check_cycle("tb2b second", c - 9, 8'b0000_0110, 4, 1);
      tick();
    end
    chk("tb2b rises", 32'(rises), 32'd8);
    chk("tb2b rx", 32'(rx), 32'h66);

    // Reset sampled at edge 6 aborts: all low from cycle 7, no done.
    launch(8'b0000_1011, 4'd4, 8'd2);
    for (int c = 1; c <= 6; c++) begin
      check_cycle("treset", c, 8'b0000_1011, 4, 2);
      if (c == 6) reset = 1'b1;
      tick();
    end
    reset = 1'b0;
    chk("treset c7 value", 32'(value_o), 32'd0);
    chk("treset c7 update", 32'(update_o), 32'd0);
    chk("treset c7 busy", 32'(busy_o), 32'd0);
    chk("treset c7 done", 32'(done_o), 32'd0);
    for (int c = 7; c <= 20; c++) begin
      if (value_o !== 1'b0 || update_o !== 1'b0 || busy_o !== 1'b0 || done_o !== 1'b0) begin
        stray++;
      end
      tick();
    end
    chk("treset stray activity", 32'(stray), 32'd0);

    launch(8'b0000_1011, 4'd4, 8'd2);
    run("tafter", 8'b0000_1011, 4, 2, 19);
    chk("tafter rises", 32'(rises), 32'd4);
    chk("tafter rx", 32'(rx[3:0]), 32'b1011);
    chk("tafter detect at rise", 32'(det_rise), 32'd4);

    $display("%0d/%0d checks passed", n_checks - n_fail, n_checks);
    $finish;
  end

endmodule
